bcd_down_timer: RTL and testbench

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

---
 rtl/bcd_down_timer_pkg.sv | 15 +
 rtl/bcd_down_timer_if.sv | 26 ++
 rtl/bcd_digit_dec.sv | 25 ++
 rtl/bcd_down_timer.sv | 109 ++++++++++
 tb/tb_bcd_down_timer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the BCD down timer: state codes, digit width, digit maximum.
// Pure declarations, no latency or backpressure.
package bcd_down_timer_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_PAUSED  = 2'd2;
  localparam state_t ST_EXPIRED = 2'd3;

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle of the BCD down timer; master drives requests, slave is the timer.
// Level/pulse signals only, no handshake or backpressure.
interface bcd_down_timer_if #(parameter int DIGITS = 2);
  import bcd_down_timer_pkg::*;

  logic                      tick;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   load_val;
  logic                      start;
  logic                      pause;
  logic [BCD_W*DIGITS-1:0]   q;
  logic                      busy;
  logic                      done;
  logic                      load_err;

  modport master (
    output tick, load, load_val, start, pause,
    input  q, busy, done, load_err
  );

  modport slave (
    input  tick, load, load_val, start, pause,
    output q, busy, done, load_err
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement with borrow chain; purely combinational, 0 cycles.
// No backpressure: borrow-in 0 passes the digit through unchanged.
module bcd_digit_dec
  import bcd_down_timer_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             bin,
  output logic [BCD_W-1:0] q,
  output logic             bout
);

  always_comb begin
    q    = d;
    bout = 1'b0;
    if (bin) begin
      if (d == '0) begin
        q    = BCD_MAX;
        bout = 1'b1;
      end else begin
        q = d - BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable BCD down counter with pause, expiry pulse and optional auto-reload.
// All outputs registered, 1 cycle after the triggering edge; no backpressure.
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic             clk,
  input logic             reset,
  bcd_down_timer_if.slave bus
);

  localparam int W = BCD_W * DIGITS;

  state_t         state_r, state_nx;
  logic [W-1:0]   q_r, q_nx, reload_r, reload_nx, q_dec;
  logic [DIGITS:0] borrow;
  logic           busy_r, done_r, err_r;
  logic           done_nx, err_nx, load_ok, underflow;

  assign borrow[0] = 1'b1;
  assign underflow = borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_dec u_dig (
      .d    (q_r[g*BCD_W +: BCD_W]),
      .bin  (borrow[g]),
      .q    (q_dec[g*BCD_W +: BCD_W]),
      .bout (borrow[g+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[i*BCD_W +: BCD_W] > BCD_MAX) load_ok = 1'b0;
    end
  end

  // A load request, valid or not, pre-empts everything else that cycle.
  always_comb begin
    state_nx  = state_r;
    q_nx      = q_r;
    reload_nx = reload_r;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        q_nx      = bus.load_val;
        reload_nx = bus.load_val;
        state_nx  = ST_IDLE;
      end else begin
        err_nx = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && q_r != '0) state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_nx = ST_PAUSED;
          end else if (bus.tick && !underflow) begin
            q_nx = q_dec;
            if (q_dec == '0) begin
              state_nx = ST_EXPIRED;
              done_nx  = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (!bus.pause) state_nx = ST_RUN;
        end
        ST_EXPIRED: begin
          if (AUTO_RELOAD && reload_r != '0) begin
            q_nx     = reload_r;
            state_nx = ST_RUN;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      q_r      <= '0;
      reload_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nx;
      q_r      <= q_nx;
      reload_r <= reload_nx;
      busy_r   <= (state_nx == ST_RUN) || (state_nx == ST_PAUSED);
      done_r   <= done_nx;
      err_r    <= err_nx;
    end
  end

  assign bus.q        = q_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.load_err = err_r;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Drives a plain and an auto-reload timer with identical directed and random stimulus
// and compares both against an integer-arithmetic reference model.
module tb_bcd_down_timer;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         tk, ld, st, ps;
  logic [W-1:0] lv;

  int ncmp  = 0;
  int nfail = 0;

  int m_cnt [2];
  int m_rld [2];
  int m_mode[2];
  bit m_done[2];
  bit m_err [2];

  bcd_down_timer_if #(.DIGITS(DIGITS)) bi0 ();
  bcd_down_timer_if #(.DIGITS(DIGITS)) bi1 ();

  assign bi0.tick = tk;  assign bi0.load = ld;  assign bi0.load_val = lv;
  assign bi0.start = st; assign bi0.pause = ps;
  assign bi1.tick = tk;  assign bi1.load = ld;  assign bi1.load_val = lv;
  assign bi1.start = st; assign bi1.pause = ps;

  bcd_down_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bi0.slave)
  );
  bcd_down_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bi1.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r;
    int v;
    v = n;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_rld[m] = 0; m_mode[m] = M_IDLE;
      m_done[m] = 1'b0; m_err[m] = 1'b0;
    end
  endtask

  // Model m == 1 is the auto-reload variant.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      m_done[m] = 1'b0;
      m_err[m]  = 1'b0;
      if (ld) begin
        if (bcd_ok(lv)) begin
          m_cnt[m] = bcd2int(lv); m_rld[m] = m_cnt[m]; m_mode[m] = M_IDLE;
        end else begin
          m_err[m] = 1'b1;
        end
      end else if (m_mode[m] == M_IDLE) begin
        if (st && m_cnt[m] != 0) m_mode[m] = M_RUN;
      end else if (m_mode[m] == M_RUN) begin
        if (ps) m_mode[m] = M_PAUSED;
        else if (tk) begin
          m_cnt[m] = m_cnt[m] - 1;
          if (m_cnt[m] == 0) begin m_mode[m] = M_EXP; m_done[m] = 1'b1; end
        end
      end else if (m_mode[m] == M_PAUSED) begin
        if (!ps) m_mode[m] = M_RUN;
      end else begin
        if (m == 1 && m_rld[m] != 0) begin m_cnt[m] = m_rld[m]; m_mode[m] = M_RUN; end
      end
    end
  endtask

  task automatic chk(input string tag, input int m, input logic [W-1:0] q,
                     input logic busy, input logic done, input logic err);
    logic [W-1:0] eq;
    logic eb;
    eq = int2bcd(m_cnt[m]);
    eb = (m_mode[m] == M_RUN) || (m_mode[m] == M_PAUSED);
    ncmp++;
    assert (q === eq) else begin
      nfail++; $error("FAIL %s.q[%0d] observed %h expected %h", tag, m, q, eq);
    end
    ncmp++;
    assert (busy === eb) else begin
      nfail++; $error("FAIL %s.busy[%0d] observed %b expected %b", tag, m, busy, eb);
    end
    ncmp++;
    assert (done === m_done[m]) else begin
      nfail++; $error("FAIL %s.done[%0d] observed %b expected %b", tag, m, done, m_done[m]);
    end
    ncmp++;
    assert (err === m_err[m]) else begin
      nfail++; $error("FAIL %s.load_err[%0d] observed %b expected %b", tag, m, err, m_err[m]);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, 0, bi0.q, bi0.busy, bi0.done, bi0.load_err);
    chk(tag, 1, bi1.q, bi1.busy, bi1.done, bi1.load_err);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed mid-cycle so its effect is seen without any clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #2;
    reset = 1'b1;
  endtask

  task automatic do_load(input logic [W-1:0] v, input string tag);
    ld = 1'b1; lv = v;
    step(tag);
    ld = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int guard;
    tk = 1'b0; ld = 1'b0; st = 1'b0; ps = 1'b0; lv = '0;
    reset = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #4;
    reset = 1'b1;
    step("post_reset");

    // Full countdown 25 -> 00 with a single done pulse.
    do_load(8'h25, "load25");
    st = 1'b1; step("start25"); st = 1'b0;
    tk = 1'b1;
    ndone = 0;
    for (int i = 0; i < 27; i++) begin
      step("count25");
      if (bi0.done === 1'b1) ndone++;
    end
    tk = 1'b0;
    ncmp++;
    assert (ndone === 1) else begin
      nfail++; $error("FAIL done_pulses observed %0d expected 1", ndone);
    end

    // Invalid BCD load is rejected.
    do_load(8'h3A, "bad_load");
    step("bad_load_after");

    // Pause at 07 for five cycles, then resume.
    do_load(8'h10, "load10");
    st = 1'b1; step("start10"); st = 1'b0;
    tk = 1'b1;
    guard = 0;
    while (m_cnt[0] != 7 && guard < 20) begin
      step("run10");
      guard++;
    end
    ncmp++;
    assert (guard < 20) else begin
      nfail++; $error("FAIL reach07 observed %0d cycles expected <20", guard);
    end
    ps = 1'b1;
    repeat (5) step("paused07");
    ps = 1'b0;
    repeat (3) step("resume");
    tk = 1'b0;

    // Load with start in the same cycle: load wins.
    ld = 1'b1; st = 1'b1; lv = 8'h05;
    step("load_start");
    ld = 1'b0; st = 1'b0;
    step("idle05");
    st = 1'b1; step("start05"); st = 1'b0;

    // Reload sequence 03,02,01,00,03,...
    do_load(8'h03, "load03");
    st = 1'b1; step("start03"); st = 1'b0;
    tk = 1'b1;
    repeat (12) step("reload03");
    tk = 1'b0;

    // Reset mid-count at 42.
    do_load(8'h45, "load45");
    st = 1'b1; step("start45"); st = 1'b0;
    tk = 1'b1;
    repeat (3) step("run45");
    async_reset("reset_at42");
    repeat (3) step("after_reset");
    tk = 1'b0;

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      ld = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < DIGITS; i++)
        lv[i*4 +: 4] = ($urandom_range(0, 11) == 0) ? 4'(10 + $urandom_range(0, 5))
                                                    : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) lv = lv & 8'h03;
      st = ($urandom_range(0, 5) == 0);
      ps = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 3) != 0);
      step("random");
      if ($urandom_range(0, 299) == 0) async_reset("random_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
